// File: rtl/legv8_pkg.sv
// legv8_pkg: LEGv8 opcodes, writer op codes, offset widths and FSM states shared by encoder and decoder
package legv8_pkg;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;
    localparam int DT_W = 9;
    localparam int CB_W = 19;
    localparam int B_W  = 26;
    typedef enum logic [2:0] {IN_LDUR, IN_STUR, IN_ADD, IN_SUB, IN_AND, IN_ORR, IN_CBZ, IN_B} in_op_t;
    typedef enum logic [2:0] {IDLE, RUN, WRITE, FULL, DONE} state_t;
    // true when the sign-extended imm is representable in w signed bits
    function automatic logic fits(input logic [25:0] imm, input int w);
        logic [25:0] s;
        s = 26'($signed(imm) >>> (w - 1));
        return s == '0 || s == '1;
    endfunction
endpackage

// File: rtl/legv8_inst_encode.sv
// legv8_inst_encode: combinational field bundle -> 32-bit LEGv8 word plus immediate range flag
//   op/rd/rn/rm/imm in: writer op code and fields; wdata out: encoded word; range_ok out: imm fits format
module legv8_inst_encode import legv8_pkg::*; (
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    output logic [31:0] wdata,
    output logic        range_ok
);
    logic [10:0] r_op;
    assign r_op = op == IN_ADD ? OP_ADD : op == IN_SUB ? OP_SUB : op == IN_AND ? OP_AND : OP_ORR;
    assign wdata = op == IN_B    ? {OP_B, imm} :
                   op == IN_CBZ  ? {OP_CBZ, imm[18:0], rd} :
                   op == IN_LDUR ? {OP_LDUR, imm[8:0], 2'b00, rn, rd} :
                   op == IN_STUR ? {OP_STUR, imm[8:0], 2'b00, rn, rd} :
                                   {r_op, rm, 6'b0, rn, rd};
    assign range_ok = op == IN_CBZ ? fits(imm, CB_W) :
                      (op == IN_LDUR || op == IN_STUR) ? fits(imm, DT_W) : 1'b1;
endmodule

// File: rtl/legv8_inst_writer.sv
// legv8_inst_writer: packs field bundles into LEGv8 words and writes them sequentially into imem
//   start/base_addr/stop: run control; in_valid/in_ready/in_*: field bundle handshake
//   imem_we/imem_addr/imem_wdata: one-cycle registered write; count/done/err: run status
module legv8_inst_writer import legv8_pkg::*; #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    state_t state;
    logic stop_q, ok, accept;
    logic [31:0] wdata;
    assign in_ready = state == RUN;
    assign accept = in_valid & in_ready;
    legv8_inst_encode u_enc (
        .op(in_op), .rd(in_rd), .rn(in_rn), .rm(in_rm), .imm(in_imm),
        .wdata(wdata), .range_ok(ok)
    );
    // imem_addr doubles as the write pointer; it advances at the end of each WRITE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= RUN;
                    imem_addr <= base_addr;
                    count     <= '0;
                    done      <= 1'b0;
                    stop_q    <= 1'b0;
                end
                RUN: begin
                    err <= accept & ~ok;
                    if (accept && ok) begin
                        state      <= WRITE;
                        imem_we    <= 1'b1;
                        imem_wdata <= wdata;
                        stop_q     <= stop;
                    end else if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WRITE: begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                    count     <= count + (ADDR_W+1)'(1);
                    if (stop_q || stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else
                        state <= count == LAST ? FULL : RUN;
                end
                FULL: if (stop) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_inst_writer.sv
// tb_legv8_inst_writer: table-driven encoding checks with a write scoreboard plus run-control corner sequences
module tb_legv8_inst_writer;
    localparam int AW = 2;
    localparam int DEPTH = 1 << AW;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [2:0] in_op = '0;
    logic [4:0] in_rd = '0, in_rn = '0, in_rm = '0;
    logic [25:0] in_imm = '0;
    logic in_ready, imem_we, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [AW:0] count;
    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [25:0] imm;
        logic [31:0] wdata;
        logic        ok;
    } vec_t;
    vec_t vecs [16];
    logic [AW+31:0] q [$];
    logic [AW+31:0] e_m;
    int compared = 0, mismatched = 0;
    logic [AW-1:0] mptr = '0, nb = '0;
    int mcount = 0;
    always #5 clk = ~clk;
    legv8_inst_writer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count), .done(done), .err(err)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_we: addr %h data %h with no write expected", imem_addr, imem_wdata);
            end else begin
                e_m = q.pop_front();
                chk("we_addr", 32'(imem_addr), 32'(e_m[AW+31:32]));
                chk("we_data", imem_wdata, e_m[31:0]);
            end
        end
    end
    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        mptr = b;
        mcount = 0;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_count", 32'(count), 0);
        chk("start_done", 32'(done), 0);
    endtask
    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_done", 32'(done), 1);
        chk("stop_ready", 32'(in_ready), 0);
        chk("stop_count", 32'(count), 32'(mcount));
    endtask
    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op = v.op;
        in_rd = v.rd;
        in_rn = v.rn;
        in_rm = v.rm;
        in_imm = v.imm;
    endtask
    task automatic send(input vec_t v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: in_ready %b want 1", in_ready);
            return;
        end
        drive(v);
        if (v.ok) q.push_back({mptr, v.wdata});
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_n1", 32'(err), 32'(!v.ok));
        chk("ready_n1", 32'(in_ready), 32'(!v.ok));
        if (v.ok) begin
            mptr = mptr + 1'b1;
            mcount++;
        end
        @(negedge clk);
        chk("err_n2", 32'(err), 0);
        chk("count", 32'(count), 32'(mcount));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        vecs[0]  = '{3'd2, 5'd1,  5'd2,  5'd3,  26'd0,        32'h8B030041, 1'b1};
        vecs[1]  = '{3'd0, 5'd5,  5'd6,  5'd31, 26'h3FFFFFF,  32'hF85FF0C5, 1'b1};
        vecs[2]  = '{3'd1, 5'd5,  5'd6,  5'd0,  26'h3FFFFFF,  32'hF81FF0C5, 1'b1};
        vecs[3]  = '{3'd6, 5'd7,  5'd9,  5'd9,  26'd4,        32'hB4000087, 1'b1};
        vecs[4]  = '{3'd7, 5'd3,  5'd4,  5'd5,  26'h3FFFFFE,  32'h17FFFFFE, 1'b1};
        vecs[5]  = '{3'd0, 5'd5,  5'd6,  5'd0,  26'd256,      32'h0,        1'b0};
        vecs[6]  = '{3'd3, 5'd31, 5'd0,  5'd31, 26'd0,        32'hCB1F001F, 1'b1};
        vecs[7]  = '{3'd4, 5'd2,  5'd3,  5'd4,  26'd0,        32'h8A040062, 1'b1};
        vecs[8]  = '{3'd1, 5'd1,  5'd1,  5'd0,  26'h3FFFEFF,  32'h0,        1'b0};
        vecs[9]  = '{3'd5, 5'd9,  5'd10, 5'd11, 26'd0,        32'hAA0B0149, 1'b1};
        vecs[10] = '{3'd0, 5'd0,  5'd1,  5'd0,  26'd255,      32'hF84FF020, 1'b1};
        vecs[11] = '{3'd0, 5'd0,  5'd1,  5'd0,  26'h3FFFF00,  32'hF8500020, 1'b1};
        vecs[12] = '{3'd6, 5'd3,  5'd0,  5'd0,  26'h3FFFFFF,  32'hB4FFFFE3, 1'b1};
        vecs[13] = '{3'd6, 5'd1,  5'd0,  5'd0,  26'h0040000,  32'h0,        1'b0};
        vecs[14] = '{3'd6, 5'd1,  5'd0,  5'd0,  26'h003FFFF,  32'hB47FFFE1, 1'b1};
        vecs[15] = '{3'd7, 5'd0,  5'd0,  5'd0,  26'h1FFFFFF,  32'h15FFFFFF, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 0);
        do_start('0);
        for (int i = 0; i < 16; i++) begin
            if (mcount == DEPTH) begin
                chk("full_ready", 32'(in_ready), 0);
                do_stop();
                nb = nb + 2'd2;
                do_start(nb);
            end
            send(vecs[i]);
            if (i == 1) begin
                start = 1'b1;
                base_addr = 2'd3;
                @(negedge clk);
                start = 1'b0;
                chk("start_ignored_ready", 32'(in_ready), 1);
            end
        end
        drive('{3'd2, 5'd4, 5'd5, 5'd6, 26'd0, 32'h0, 1'b1});
        stop = 1'b1;
        q.push_back({mptr, 32'h8B0600A4});
        @(negedge clk);
        in_valid = 1'b0;
        stop = 1'b0;
        mptr = mptr + 1'b1;
        mcount++;
        chk("stopacc_ready", 32'(in_ready), 0);
        chk("stopacc_done_n1", 32'(done), 0);
        @(negedge clk);
        chk("stopacc_done", 32'(done), 1);
        chk("stopacc_count", 32'(count), 32'(mcount));
        nb = nb + 2'd2;
        do_start(nb);
        drive('{3'd3, 5'd1, 5'd1, 5'd1, 26'd0, 32'h0, 1'b1});
        q.push_back({mptr, 32'hCB010021});
        @(negedge clk);
        in_valid = 1'b0;
        stop = 1'b1;
        mptr = mptr + 1'b1;
        mcount++;
        @(negedge clk);
        stop = 1'b0;
        chk("stopwr_done", 32'(done), 1);
        chk("stopwr_count", 32'(count), 32'(mcount));
        do_start(2'd3);
        drive('{3'd2, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 1'b1});
        for (int i = 0; i < 12; i++) begin
            in_rd = 5'(i);
            if (in_ready) begin
                q.push_back({mptr, 32'h8B000000 | 32'(i)});
                mptr = mptr + 1'b1;
                mcount++;
            end
            @(negedge clk);
            chk("full_err", 32'(err), 0);
        end
        in_valid = 1'b0;
        chk("full_ready_t5", 32'(in_ready), 0);
        chk("full_count_t5", 32'(count), DEPTH);
        do_stop();
        do_start('0);
        drive(vecs[0]);
        q.push_back({mptr, 32'h8B030041});
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_we", 32'(imem_we), 0);
        chk("arst_ready", 32'(in_ready), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_wdata", imem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(2'd1);
        send(vecs[0]);
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
